// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add unsigned multiplier: one add/shift step per enabled clock,
// WIDTH+1 cycles from an accepted start to a one-cycle done pulse.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Upper half plus the selected multiplicand, one bit wider to keep the carry.
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_shift;

  always_comb begin
    sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, mcand_q} & {(WIDTH+1){acc_q[0]}});
    acc_shift = {sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    product_d = product_q;

    if (en_i) begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = RUN;
            mcand_d = a_i;
            acc_d   = {{WIDTH{1'b0}}, b_i};
            cnt_d   = '0;
          end
        end
        RUN: begin
          acc_d = acc_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d   = DONE;
            product_d = acc_shift;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the datapath registers are reset too, so an abandoned run leaves no residue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      product_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
    end
  end

  // State-decoded outputs: they hold with en_i low and never see start_i combinationally.
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign product_o = product_q;

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential shift-add multiplier controller for the MIPS multiplier path. It accepts an operand pair on a Start pulse and runs one add/shift iteration per enabled clock, using its own internal accumulator and multiplicand registers. When finished it publishes the unsigned 2·WIDTH-bit product with a one-cycle Done pulse. The CPU's mult/multu stall logic sits upstream and observes Busy/Done.

## Interface

- WIDTH, 32, operand width in bits; must be ≥ 2.
- Clk  input  1  system clock; rising-edge active.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- En  input  1  clock enable; when low all internal state and outputs hold.
- Start  input  1  request; sampled only when En=1 and state=IDLE.
- A  input  WIDTH  multiplicand, unsigned; captured on the accepted Start edge.
- B  input  WIDTH  multiplier, unsigned; captured on the accepted Start edge.
- Busy  output  1  high while state is RUN or DONE.
- Done  output  1  high for exactly one enabled cycle (state DONE).
- Product  output  2·WIDTH  last completed result; holds between completions.

## Operation

- States:
  - IDLE: wait for Start.
  - RUN: iterate, with iteration count in a counter of $clog2(WIDTH+1) bits.
  - DONE: publish result, then return to IDLE.
- IDLE, En=1, Start=1 → RUN:
  - mcand ← A
  - acc ← {WIDTH'b0, B}
  - cnt ← 0
- RUN, En=1, each edge:
  - sum = acc[2W-1:W] + (acc[0] ? mcand : 0), computed WIDTH+1 bits wide to keep the carry.
  - acc ← {sum, acc[W-1:1]}, a logical right shift that includes the carry bit.
  - cnt ← cnt+1.
  - On the edge where cnt==WIDTH-1 (the final iteration), also go to DONE and load Product ← the new acc value.
- DONE, En=1 → IDLE unconditionally. Start in DONE is ignored and not queued.
- Start in RUN or DONE is ignored and not queued. Operand changes after acceptance have no effect.
- En=0 in any state: state, cnt, acc, mcand and Product hold. Busy and Done hold their values, so an En=0 cycle in DONE stretches Done.
- Product changes only on entry to DONE or on Reset. While a new operation runs, the previous result stays visible.
- Arithmetic is unsigned modulo 2^(2W). The result is exact because the maximum product (2^W−1)² fits in 2W bits.

## Timing

- Reset asserted (asynchronous, any time, including mid-RUN):
  - state=IDLE, cnt=0, acc=0, mcand=0
  - Busy=0, Done=0, Product=0
  - A run in progress is abandoned and no Done is generated.
- After Reset deasserts, the first rising edge with En=1 and Start=1 is accepted.
- Latency with continuous En=1 and Start accepted at edge E0:
  - RUN iterations occur at edges E1..EW.
  - Product is valid and Done=1 after edge EW.
  - Done drops and Busy drops after edge EW+1.
  - Total: W+1 cycles from acceptance to Done; the next Start can be accepted at edge EW+2.
- Each En=0 cycle adds exactly one cycle to every latency above.
- Busy and Done are registered or state-decoded only; there is no combinational path from Start to any output.
- Back-to-back throughput: one product every W+2 cycles.

## Test plan

- Basic, WIDTH=32: Reset pulse, then A=3, B=5, Start for one cycle.
  - Busy=1 after E0; Done=1 after E32 for one cycle.
  - Product=64'h0000_0000_0000_000F; Busy=0 after E33.
- Extremes: A=B=32'hFFFF_FFFF → Product=64'hFFFF_FFFE_0000_0001. Then A=0, B=32'h1234_5678 → Product=0, with Done at the same latency. Product holds FFFF_FFFE_0000_0001 until the second Done.
- Ignored Start: Start A=7, B=6, then assert Start again with A=2, B=2 during RUN and during DONE.
  - Exactly one Done; Product=42.
  - Busy=0 afterwards; no second operation begins.
- Enable stall: A=10, B=10, Start, then drop En for 5 cycles mid-RUN.
  - Done arrives after E37 instead of E32; Product=100.
  - Additionally drop En in DONE: Done stays high for the stall length plus one cycle.
- Reset mid-operation: A=9, B=9, Start, then assert Reset asynchronously (between edges) at iteration 10.
  - Busy, Done and Product go to 0 immediately, with no Done pulse.
  - After release, A=4, B=4 → Product=16 with normal latency.
- Random: 1000 random operand pairs with random En gaps, compared against A*B, checking Done latency = W+1 plus the number of stall cycles.
